// File: rtl/pointwise_conv_pkg.sv
// Shared types and arithmetic helpers for the pointwise convolution stage.
// Requantization works on a 64-bit view of the accumulator so any ACCUM_WIDTH < 64 fits.
package pointwise_conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_e;

  localparam int CTRL_SHIFT_LSB = 0;
  localparam int CTRL_SHIFT_MSB = 4;
  localparam int CTRL_SAT_BIT   = 8;

  function automatic int calc_passes(input int out_ch, input int lanes);
    return (out_ch + lanes - 1) / lanes;
  endfunction

  // Rounding arithmetic shift, then clamp to [0, 2^aw-1] or keep the low aw bits.
  function automatic logic [63:0] requantize(input logic signed [63:0] acc,
                                             input logic [4:0]         shift,
                                             input logic               sat_en,
                                             input int unsigned        aw);
    logic signed [63:0] r;
    logic signed [63:0] max_v;
    if (shift != 5'd0) begin
      r = (acc + (64'sd1 <<< (shift - 5'd1))) >>> shift;
    end else begin
      r = acc;
    end
    max_v = (64'sd1 <<< aw) - 64'sd1;
    if (sat_en) begin
      if (r < 64'sd0) begin
        return 64'd0;
      end else if (r > max_v) begin
        return max_v;
      end else begin
        return r;
      end
    end else begin
      return r & max_v;
    end
  endfunction

endpackage

// File: rtl/pointwise_conv_requant_lane.sv
// One MAC lane: bias + dot product of unsigned activations with signed weights, then requantize.
// Purely combinational; the top registers the result.
module pointwise_mac_lane
  import pointwise_conv_pkg::*;
#(
  parameter int IN_CHANNELS      = 3,
  parameter int ACTIVATION_WIDTH = 8,
  parameter int WEIGHT_WIDTH     = 8,
  parameter int BIAS_WIDTH       = 16,
  parameter int ACCUM_WIDTH      = 24
) (
  input  logic [0:IN_CHANNELS-1][ACTIVATION_WIDTH-1:0] act_i,
  input  logic [0:IN_CHANNELS-1][WEIGHT_WIDTH-1:0]     weight_i,
  input  logic [BIAS_WIDTH-1:0]                        bias_i,
  input  logic [4:0]                                   shift_i,
  input  logic                                         sat_en_i,
  output logic [ACTIVATION_WIDTH-1:0]                  result_o
);

  logic signed [ACCUM_WIDTH-1:0] acc_s;
  logic signed [ACCUM_WIDTH-1:0] act_ext_s;
  logic signed [ACCUM_WIDTH-1:0] w_ext_s;

  // Accumulate at ACCUM_WIDTH, then requantize down to the activation width.
  always_comb begin
    acc_s     = {{(ACCUM_WIDTH-BIAS_WIDTH){bias_i[BIAS_WIDTH-1]}}, bias_i};
    act_ext_s = '0;
    w_ext_s   = '0;
    for (int i = 0; i < IN_CHANNELS; i++) begin
      act_ext_s = {{(ACCUM_WIDTH-ACTIVATION_WIDTH){1'b0}}, act_i[i]};
      w_ext_s   = {{(ACCUM_WIDTH-WEIGHT_WIDTH){weight_i[i][WEIGHT_WIDTH-1]}}, weight_i[i]};
      acc_s     = acc_s + act_ext_s * w_ext_s;
    end
    result_o = ACTIVATION_WIDTH'(requantize({{(64-ACCUM_WIDTH){acc_s[ACCUM_WIDTH-1]}}, acc_s},
                                            shift_i, sat_en_i, ACTIVATION_WIDTH));
  end

endmodule

// File: rtl/pointwise_conv_requant.sv
// Runtime-configurable 1x1 convolution with per-channel bias and requantization.
// LANES MAC lanes are time-multiplexed over PASSES cycles per accepted pixel.
module pointwise_conv_requant
  import pointwise_conv_pkg::*;
#(
  parameter int IN_CHANNELS      = 3,
  parameter int OUT_CHANNELS     = 3,
  parameter int LANES            = 2,
  parameter int ACTIVATION_WIDTH = 8,
  parameter int WEIGHT_WIDTH     = 8,
  parameter int BIAS_WIDTH       = 16,
  parameter int ACCUM_WIDTH      = 24,
  parameter logic signed [0:OUT_CHANNELS-1][0:IN_CHANNELS-1][WEIGHT_WIDTH-1:0] WEIGHT = '0,
  parameter logic signed [0:OUT_CHANNELS-1][BIAS_WIDTH-1:0] BIAS = '0,
  parameter int SHIFT = 0
) (
  input  logic                                       clock_i,
  input  logic                                       reset_i,
  input  logic                                       slave_valid_i,
  output logic                                       slave_ready_o,
  input  logic [IN_CHANNELS*ACTIVATION_WIDTH-1:0]    slave_data_i,
  output logic                                       master_valid_o,
  input  logic                                       master_ready_i,
  output logic [OUT_CHANNELS*ACTIVATION_WIDTH-1:0]   master_data_o,
  input  logic                                       cfg_valid_i,
  output logic                                       cfg_ready_o,
  input  logic [$clog2(OUT_CHANNELS*IN_CHANNELS+OUT_CHANNELS+1)-1:0] cfg_addr_i,
  input  logic [BIAS_WIDTH-1:0]                      cfg_data_i
);

  localparam int PASSES    = calc_passes(OUT_CHANNELS, LANES);
  localparam int PASS_W    = $clog2(PASSES + 1);
  localparam int ADDR_W    = $clog2(OUT_CHANNELS*IN_CHANNELS + OUT_CHANNELS + 1);
  localparam int CTRL_ADDR = OUT_CHANNELS*IN_CHANNELS + OUT_CHANNELS;

  state_e                                           state_q;
  logic [PASS_W-1:0]                                pass_q;
  logic                                             master_valid_q;
  logic [0:IN_CHANNELS-1][ACTIVATION_WIDTH-1:0]     pix_q;
  logic [0:OUT_CHANNELS-1][ACTIVATION_WIDTH-1:0]    result_q;
  logic [0:OUT_CHANNELS-1][0:IN_CHANNELS-1][WEIGHT_WIDTH-1:0] weight_q;
  logic [0:OUT_CHANNELS-1][BIAS_WIDTH-1:0]          bias_q;
  logic [4:0]                                       shift_q;
  logic                                             sat_en_q;

  logic [0:LANES-1][0:IN_CHANNELS-1][WEIGHT_WIDTH-1:0] lane_weight_s;
  logic [0:LANES-1][BIAS_WIDTH-1:0]                    lane_bias_s;
  logic [0:LANES-1][ACTIVATION_WIDTH-1:0]              lane_result_s;
  logic                                                cfg_hs_s;

  assign slave_ready_o  = !reset_i && ((state_q == ST_IDLE) ||
                                       ((state_q == ST_OUTPUT) && master_ready_i));
  assign cfg_ready_o    = !reset_i && (state_q == ST_IDLE);
  assign cfg_hs_s       = cfg_valid_i && cfg_ready_o;
  assign master_valid_o = master_valid_q;
  assign master_data_o  = result_q;

  // Route each lane's channel row for the current pass; lanes past the last channel see a dummy row.
  always_comb begin
    lane_weight_s = '0;
    lane_bias_s   = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int p = 0; p < PASSES; p++) begin
        lane_weight_s[l] = (pass_q == PASS_W'(p)) ?
          weight_q[(p*LANES+l < OUT_CHANNELS) ? p*LANES+l : OUT_CHANNELS-1] : lane_weight_s[l];
        lane_bias_s[l] = (pass_q == PASS_W'(p)) ?
          bias_q[(p*LANES+l < OUT_CHANNELS) ? p*LANES+l : OUT_CHANNELS-1] : lane_bias_s[l];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    pointwise_mac_lane #(
      .IN_CHANNELS     (IN_CHANNELS),
      .ACTIVATION_WIDTH(ACTIVATION_WIDTH),
      .WEIGHT_WIDTH    (WEIGHT_WIDTH),
      .BIAS_WIDTH      (BIAS_WIDTH),
      .ACCUM_WIDTH     (ACCUM_WIDTH)
    ) u_lane (
      .act_i   (pix_q),
      .weight_i(lane_weight_s[l]),
      .bias_i  (lane_bias_s[l]),
      .shift_i (shift_q),
      .sat_en_i(sat_en_q),
      .result_o(lane_result_s[l])
    );
  end

  // Config register file; only writable while idle so a pixel never sees a mixed config.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      weight_q <= WEIGHT;
      bias_q   <= BIAS;
      shift_q  <= 5'(SHIFT);
      sat_en_q <= 1'b1;
    end else if (cfg_hs_s) begin
      for (int o = 0; o < OUT_CHANNELS; o++) begin
        for (int i = 0; i < IN_CHANNELS; i++) begin
          if (cfg_addr_i == ADDR_W'(o*IN_CHANNELS + i)) begin
            weight_q[o][i] <= cfg_data_i[WEIGHT_WIDTH-1:0];
          end
        end
        if (cfg_addr_i == ADDR_W'(OUT_CHANNELS*IN_CHANNELS + o)) begin
          bias_q[o] <= cfg_data_i;
        end
      end
      if (cfg_addr_i == ADDR_W'(CTRL_ADDR)) begin
        shift_q  <= cfg_data_i[CTRL_SHIFT_MSB:CTRL_SHIFT_LSB];
        sat_en_q <= cfg_data_i[CTRL_SAT_BIT];
      end
    end
  end

  // Pixel FSM: latch, compute PASSES lane groups, then hold the result until taken.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= ST_IDLE;
      pass_q         <= '0;
      master_valid_q <= 1'b0;
      pix_q          <= '0;
      result_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (slave_valid_i) begin
            pix_q   <= slave_data_i;
            pass_q  <= '0;
            state_q <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          for (int o = 0; o < OUT_CHANNELS; o++) begin
            if (pass_q == PASS_W'(o / LANES)) begin
              result_q[o] <= lane_result_s[o % LANES];
            end
          end
          if (pass_q == PASS_W'(PASSES - 1)) begin
            pass_q         <= '0;
            master_valid_q <= 1'b1;
            state_q        <= ST_OUTPUT;
          end else begin
            pass_q <= pass_q + PASS_W'(1);
          end
        end
        ST_OUTPUT: begin
          if (master_ready_i) begin
            master_valid_q <= 1'b0;
            if (slave_valid_i) begin
              pix_q   <= slave_data_i;
              pass_q  <= '0;
              state_q <= ST_COMPUTE;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          master_valid_q <= 1'b0;
          pass_q         <= '0;
          state_q        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pointwise_conv_requant.md
# pointwise_conv_requant

Runtime-reconfigurable 1x1 (pointwise) convolution stage for the streaming pixel pipeline. Per accepted pixel, computes OUT_CHANNELS dot products over IN_CHANNELS activations using LANES parallel MAC lanes time-multiplexed over several passes. Adds a per-channel bias, then requantizes each result (rounding right shift, then saturation or wrap) back to ACTIVATION_WIDTH. Successor to the fixed-weight channel-reduction stage: weights, biases, shift and output mode are loadable through a config port, with reset values taken from parameters.

## Interface
- IN_CHANNELS, 3, input channels per pixel
- OUT_CHANNELS, 3, output channels per pixel
- LANES, 2, output channels computed per pass; PASSES = ceil(OUT_CHANNELS/LANES)
- ACTIVATION_WIDTH, 8, unsigned activation width (in and out)
- WEIGHT_WIDTH, 8, signed weight width
- BIAS_WIDTH, 16, signed bias width; also cfg data width; must be ≥ WEIGHT_WIDTH and ≥ 9
- ACCUM_WIDTH, 24, signed accumulator width; must be ≥ ACTIVATION_WIDTH+WEIGHT_WIDTH+$clog2(IN_CHANNELS)+1 and ≥ BIAS_WIDTH+1
- WEIGHT, 0, reset weights, [0:OUT_CHANNELS-1][0:IN_CHANNELS-1] signed
- BIAS, 0, reset biases, [0:OUT_CHANNELS-1] signed
- SHIFT, 0, reset shift amount, 0..31, < ACCUM_WIDTH
- clock_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- slave_valid_i  in  1  input pixel valid
- slave_ready_o  out  1  input pixel accepted when high with valid
- slave_data_i  in  IN_CHANNELS*ACTIVATION_WIDTH  channel 0 in MSBs
- master_valid_o  out  1  output pixel valid
- master_ready_i  in  1  downstream ready
- master_data_o  out  OUT_CHANNELS*ACTIVATION_WIDTH  channel 0 in MSBs
- cfg_valid_i  in  1  config write strobe
- cfg_ready_o  out  1  config write accepted when high with valid
- cfg_addr_i  in  $clog2(OUT_CHANNELS*IN_CHANNELS+OUT_CHANNELS+1)  word address
- cfg_data_i  in  BIAS_WIDTH  write data

## Operation
- Config address map:
  - 0..OUT*IN-1: weight[o][i] at o*IN+i, low WEIGHT_WIDTH bits.
  - OUT*IN..OUT*IN+OUT-1: bias[o].
  - OUT*IN+OUT: control, where [4:0] = shift and bit 8 = sat_en.
  - Out-of-range addresses are ignored. cfg_ready_o = state==IDLE && !reset_i; writes take effect next cycle.
- States:
  - IDLE: slave_ready_o=1. A handshake latches slave_data_i, sets pass=0 and moves to COMPUTE.
  - COMPUTE: each cycle, lane l computes out channel o=pass*LANES+l and writes its result register; lanes with o≥OUT_CHANNELS are discarded. After pass PASSES-1, move to OUTPUT.
  - OUTPUT: master_valid_o=1 and master_data_o is held stable. On a master handshake: if slave_valid_i is also high, accept the new pixel and go to COMPUTE; otherwise go to IDLE.
- slave_ready_o = !reset_i && (IDLE || (OUTPUT && master_ready_i)). This is a combinational ready path.
- Lane arithmetic: acc = bias[o] + Σ zero-extended act[i] × signed weight[o][i], computed at ACCUM_WIDTH.
  - shift>0: r = (acc + 2^(shift-1)) >>> shift (arithmetic); shift=0: r = acc.
  - sat_en=1: clamp r to [0, 2^AW-1]; sat_en=0: take r[AW-1:0] (wrap).
- Config is sampled during COMPUTE. Because writes are only accepted in IDLE, a pixel always sees one consistent config.

## Timing
- Reset (asynchronous assert):
  - state=IDLE, pass=0, master_valid_o=0, slave_ready_o=0, cfg_ready_o=0.
  - weights←WEIGHT, biases←BIAS, shift←SHIFT, sat_en←1. Result registers are cleared to 0.
- Reset mid-computation drops the pixel in flight; no output is produced for it.
- Latency: a handshake at edge E0 gives master_valid_o=1 after edge E0+PASSES.
- Throughput: with master_ready_i held high, one pixel per PASSES+1 cycles (back-to-back via the OUTPUT accept path).
- master_valid_o stays high until the handshake. Stalls of any length are lossless.

## Structure
- Package pointwise_conv_pkg holds:
  - state enum {IDLE, COMPUTE, OUTPUT};
  - control-word field positions;
  - function requantize(acc, shift, sat_en);
  - function computing PASSES.
- Sub-module pointwise_mac_lane: combinational dot product plus bias plus requantize for one lane. The top instantiates LANES of them, plus the FSM, config register file and result registers.

## Test plan
- Defaults with WEIGHT=identity(3×3), BIAS=0, SHIFT=0: input {10,20,30} → output {10,20,30}, master_valid_o exactly 2 cycles after acceptance (PASSES=2).
- Saturation, weight[0][*]={127,127,127}: input {255,255,255} → channel 0 = 255. Then bias[1]=-1000 with weight[1][*]=1 and input {1,1,1} → channel 1 = 0.
- Wrap and rounding: write control = shift 2, sat_en 0; weight[0]={1,0,0}, input {7,…} → (7+2)>>2 = 2. With weight[0]={3,3,3} and input {255,255,255}, shift 0 → 2295 mod 256 = 247.
- Backpressure: hold master_ready_i low for 10 cycles → data stable, slave_ready_o=0 throughout. When ready rises with slave_valid_i high → both handshakes occur in the same cycle.
- Config gating: cfg_valid_i during COMPUTE → cfg_ready_o=0 and the weight is unchanged. The same write in IDLE updates the next pixel's result. Out-of-range address → no register changes.
- Async reset asserted in the middle of COMPUTE → outputs drop immediately. After release: no stale master_valid_o, and weights are back to the WEIGHT values.
